// File: rtl/deser_rr_arbiter.sv
// deser_rr_arbiter
// Round-robin arbiter that lets one of REQ_CNT serial requesters own a
// shared deserializer for one DATA_W-bit word at a time. The owner's bit
// stream is forwarded combinationally, and the index of the last owner to
// complete a word is reported on word_id_o.
//
// Optional feature macro: DESER_ARB_TIMEOUT_EN
//   When defined, a stall watchdog aborts an owner that supplies no valid
//   bit for TIMEOUT_CYC consecutive busy cycles. The abort pulses abort_o and
//   ser_srst_o for one cycle and frees the deserializer.
//   When undefined, abort_o and ser_srst_o are tied low and a stalled owner
//   keeps the grant indefinitely.

module deser_rr_arbiter #(
   parameter int REQ_CNT     = 4,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic [REQ_CNT-1:0]         req_i,
   input  logic [REQ_CNT-1:0]         data_i,
   input  logic [REQ_CNT-1:0]         data_val_i,
   output logic [REQ_CNT-1:0]         gnt_o,
   output logic                       ser_data_o,
   output logic                       ser_data_val_o,
   output logic                       ser_srst_o,
   output logic [$clog2(REQ_CNT)-1:0] word_id_o,
   output logic                       abort_o
);

   localparam int IDX_W = $clog2(REQ_CNT);
   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(REQ_CNT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic [REQ_CNT-1:0] gnt_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   last_owner_q;
   logic [IDX_W-1:0]   word_id_q;
   logic [CNT_W-1:0]   bit_cnt_q;

   logic [IDX_W-1:0]   pick_idx;
   logic               any_req;
   logic               owner_bit;
   logic               owner_val;
   logic               take_grant;
   logic               word_done;
   logic               timeout_hit;

   // Scan the request vector starting one past the previous owner and wrap
   // around, so the requester that just finished has the lowest priority.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [REQ_CNT-1:0] req,
      input logic [IDX_W-1:0]   last
   );
      logic [IDX_W-1:0] result;
      logic             found;
      int               cand;
      result = '0;
      found  = 1'b0;
      for (int off = 1; off <= REQ_CNT; off++) begin
         cand = (int'(last) + off) % REQ_CNT;
         if (!found && req[cand]) begin
            found  = 1'b1;
            result = IDX_W'(cand);
         end
      end
      return result;
   endfunction

   assign any_req   = |req_i;
   assign pick_idx  = rr_pick(req_i, last_owner_q);
   assign owner_bit = data_i[owner_q];
   assign owner_val = data_val_i[owner_q];

   assign gnt_o     = gnt_q;
   assign word_id_o = word_id_q;

`ifdef DESER_ARB_TIMEOUT_EN

   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

   logic [STALL_W-1:0] stall_q;
   logic               abort_q;

   // The watchdog fires on the busy cycle that would bring the count of
   // consecutive owner stall cycles up to TIMEOUT_CYC.
   assign timeout_hit = (state_q == BUSY) && !owner_val && (stall_q == STALL_LAST);

   // Count consecutive busy cycles without an owner bit; register the abort
   // so both abort strobes appear as a clean one-cycle pulse.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         stall_q <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= timeout_hit;
         if (take_grant || timeout_hit || ((state_q == BUSY) && owner_val)) begin
            stall_q <= '0;
         end else if (state_q == BUSY) begin
            stall_q <= stall_q + STALL_W'(1);
         end
      end
   end

   assign abort_o    = abort_q;
   assign ser_srst_o = abort_q;

`else

   // Without the watchdog no abort can occur. The range check on the stall
   // limit is never true for a legal value and keeps the parameter referenced.
   assign timeout_hit = (TIMEOUT_CYC < 0);
   assign abort_o     = 1'b0;
   assign ser_srst_o  = 1'b0;

`endif

   // State register; reset forces IDLE immediately, discarding any partial word.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the owner bit forwarding to the shared deserializer.
   always_comb begin
      state_d        = state_q;
      take_grant     = 1'b0;
      word_done      = 1'b0;
      ser_data_o     = 1'b0;
      ser_data_val_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               take_grant = 1'b1;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            ser_data_o     = owner_bit;
            ser_data_val_o = owner_val;
            if (owner_val && (bit_cnt_q == LAST_BIT)) begin
               word_done = 1'b1;
               state_d   = IDLE;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Grant, owner tracking, bit counting and completion reporting. The grant
   // is held until the word completes or is aborted, regardless of req_i.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         gnt_q        <= '0;
         owner_q      <= '0;
         last_owner_q <= LAST_INDEX;
         word_id_q    <= '0;
         bit_cnt_q    <= '0;
      end else begin
         if (take_grant) begin
            gnt_q     <= REQ_CNT'(1) << pick_idx;
            owner_q   <= pick_idx;
            bit_cnt_q <= '0;
         end else if (word_done) begin
            gnt_q        <= '0;
            word_id_q    <= owner_q;
            last_owner_q <= owner_q;
            bit_cnt_q    <= '0;
         end else if (timeout_hit) begin
            gnt_q        <= '0;
            last_owner_q <= owner_q;
            bit_cnt_q    <= '0;
         end else if ((state_q == BUSY) && owner_val) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// tb_deser_rr_arbiter
// Self-checking bench for deser_rr_arbiter with REQ_CNT=4, DATA_W=16.
// Build with DESER_ARB_TIMEOUT_EN defined to exercise the stall watchdog
// (TIMEOUT_CYC=8); otherwise the stall sequence expects the grant to be held.

module tb_deser_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
`ifdef DESER_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic       clk_i      = 1'b0;
   logic       arst_i     = 1'b0;
   logic [3:0] req_i      = '0;
   logic [3:0] data_i     = '0;
   logic [3:0] data_val_i = '0;
   logic [3:0] gnt_o;
   logic       ser_data_o;
   logic       ser_data_val_o;
   logic       ser_srst_o;
   logic [1:0] word_id_o;
   logic       abort_o;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 when nobody owns the deserializer),
   // bits accepted so far, previous owner, last completed word's owner,
   // consecutive stall cycles and the abort pulse visible this cycle.
   int m_owner;
   int m_cnt;
   int m_last;
   int m_wid;
   int m_stall;
   bit m_abort;

   logic [15:0] cap_word;
   int          abort_seen;

   typedef struct {
      logic [3:0] req;
      logic [3:0] data;
      logic [3:0] val;
      logic [3:0] gnt;
      logic       ser;
      logic       sval;
      logic [1:0] wid;
   } vec_t;

   vec_t vecs[5];

   deser_rr_arbiter #(
      .REQ_CNT     (N),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i          (clk_i),
      .arst_i         (arst_i),
      .req_i          (req_i),
      .data_i         (data_i),
      .data_val_i     (data_val_i),
      .gnt_o          (gnt_o),
      .ser_data_o     (ser_data_o),
      .ser_data_val_o (ser_data_val_o),
      .ser_srst_o     (ser_srst_o),
      .word_id_o      (word_id_o),
      .abort_o        (abort_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_i = ~clk_i;

   task automatic checkValue(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rrPick(input logic [3:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic modelReset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
      m_wid   = 0;
      m_stall = 0;
      m_abort = 1'b0;
   endtask

   // Advance the model across the coming clock edge using the applied inputs.
   task automatic modelStep();
      bit next_abort;
      next_abort = 1'b0;
      if (m_owner < 0) begin
         if (req_i != 4'b0000) begin
            m_owner = rrPick(req_i, m_last);
            m_cnt   = 0;
            m_stall = 0;
         end
      end else if (data_val_i[m_owner]) begin
         m_stall = 0;
         if (m_cnt == DW - 1) begin
            m_wid   = m_owner;
            m_last  = m_owner;
            m_cnt   = 0;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end else begin
`ifdef DESER_ARB_TIMEOUT_EN
         m_stall++;
         if (m_stall == TO) begin
            next_abort = 1'b1;
            m_last     = m_owner;
            m_owner    = -1;
            m_cnt      = 0;
            m_stall    = 0;
         end
`endif
      end
      m_abort = next_abort;
   endtask

   task automatic checkOutput();
      int exp_gnt;
      int exp_ser;
      int exp_sval;
      exp_gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
      exp_ser  = (m_owner < 0) ? 0 : int'(data_i[m_owner]);
      exp_sval = (m_owner < 0) ? 0 : int'(data_val_i[m_owner]);
      checkValue("gnt", int'(gnt_o), exp_gnt);
      checkValue("ser_data", int'(ser_data_o), exp_ser);
      checkValue("ser_data_val", int'(ser_data_val_o), exp_sval);
      checkValue("word_id", int'(word_id_o), m_wid);
      checkValue("abort", int'(abort_o), int'(m_abort));
      checkValue("ser_srst", int'(ser_srst_o), int'(m_abort));
   endtask

   // One cycle: drive after the falling edge, check, then step the model.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic [3:0] v);
      @(negedge clk_i);
      req_i      = r;
      data_i     = d;
      data_val_i = v;
      #1;
      checkOutput();
      if (ser_data_val_o) cap_word = {cap_word[14:0], ser_data_o};
      if (abort_o) abort_seen++;
      modelStep();
   endtask

   // Assert reset between clock edges and confirm it takes effect at once.
   task automatic doReset();
      @(negedge clk_i);
      #2 arst_i = 1'b1;
      #1;
      checkValue("rst_gnt", int'(gnt_o), 0);
      checkValue("rst_word_id", int'(word_id_o), 0);
      checkValue("rst_abort", int'(abort_o), 0);
      checkValue("rst_srst", int'(ser_srst_o), 0);
      modelReset();
      @(negedge clk_i);
      req_i      = '0;
      data_i     = '0;
      data_val_i = '0;
      arst_i     = 1'b0;
   endtask

   function automatic logic [3:0] rnd4();
      return 4'($urandom);
   endfunction

   initial begin
      logic [15:0] pats[5];
      logic [3:0]  d;
      logic [3:0]  v;
      logic [3:0]  r;
      int          bits;
      int          e;

      // Directed vectors from reset with req 0101: idle, owner-0 bit,
      // non-owner valids ignored, grant held after req drops.
      vecs[0] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[1] = '{4'b0101, 4'b0001, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0};
      vecs[2] = '{4'b0101, 4'b1110, 4'b1110, 4'b0001, 1'b0, 1'b0, 2'd0};
      vecs[3] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0};
      vecs[4] = '{4'b0000, 4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0};

      pats[0] = 16'hA5C3;
      pats[1] = 16'h1234;
      pats[2] = 16'h0F0F;
      pats[3] = 16'hC001;
      pats[4] = 16'h5A3C;

      cap_word   = '0;
      abort_seen = 0;
      modelReset();

      // Table vectors, then finish owner 0's word and hand over to owner 2.
      doReset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         req_i      = vecs[i].req;
         data_i     = vecs[i].data;
         data_val_i = vecs[i].val;
         #1;
         checkValue("vec_gnt", int'(gnt_o), int'(vecs[i].gnt));
         checkValue("vec_ser", int'(ser_data_o), int'(vecs[i].ser));
         checkValue("vec_sval", int'(ser_data_val_o), int'(vecs[i].sval));
         checkValue("vec_wid", int'(word_id_o), int'(vecs[i].wid));
         modelStep();
      end
      for (int i = 0; i < 13; i++) applyStimulus(4'b0101, rnd4(), 4'b0001 | rnd4());
      applyStimulus(4'b0101, rnd4(), rnd4());
      checkValue("gap_idle_gnt", int'(gnt_o), 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'b0101, rnd4(), 4'b0100 | rnd4());
         if (i == 0) checkValue("second_gnt", int'(gnt_o), 4);
      end
      applyStimulus(4'b0000, rnd4(), rnd4());
      checkValue("second_wid", int'(word_id_o), 2);

      // All requesting: grant order 0,1,2,3,0 and MSB-first word integrity.
      doReset();
      for (int w = 0; w < 5; w++) begin
         e = w % 4;
         applyStimulus(4'b1111, rnd4(), 4'b0000);
         cap_word = '0;
         for (int b = 0; b < 16; b++) begin
            d    = rnd4();
            d[e] = pats[w][15 - b];
            applyStimulus(4'b1111, d, 4'b1111);
            if (b == 0) checkValue("rr_order_gnt", int'(gnt_o), 1 << e);
         end
         checkValue("word_data", int'(cap_word), int'(pats[w]));
      end

      // Owner 1 drops req after 5 bits with gapped valids; grant must hold.
      doReset();
      applyStimulus(4'b0010, rnd4(), rnd4());
      bits = 0;
      for (int c = 0; c < 40 && bits < 16; c++) begin
         v    = rnd4();
         v[1] = (c % 2 == 0);
         r    = (bits >= 5) ? 4'b1101 : 4'b1111;
         applyStimulus(r, rnd4(), v);
         checkValue("hold_gnt", int'(gnt_o), 2);
         if (v[1]) bits++;
      end
      applyStimulus(4'b1101, rnd4(), rnd4());
      checkValue("hold_wid", int'(word_id_o), 1);

      // Reset mid-word of owner 2, then a full word from a fresh counter.
      doReset();
      applyStimulus(4'b0100, rnd4(), 4'b0000);
      for (int i = 0; i < 7; i++) applyStimulus(4'b0100, rnd4(), 4'b0100 | rnd4());
      doReset();
      applyStimulus(4'b0100, rnd4(), 4'b0000);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'b0100, rnd4(), 4'b0100 | rnd4());
         if (i == 0) checkValue("rst_regrant", int'(gnt_o), 4);
      end
      applyStimulus(4'b0000, rnd4(), rnd4());
      checkValue("rst_wid", int'(word_id_o), 2);

      // Owner 3 sends 4 bits then stalls while owner 0 waits.
      applyStimulus(4'b1000, rnd4(), 4'b0000);
      for (int i = 0; i < 4; i++) applyStimulus(4'b1000, rnd4(), 4'b1000);
      abort_seen = 0;
`ifdef DESER_ARB_TIMEOUT_EN
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b1001, rnd4(), 4'b0111 & rnd4());
         if (c == 7) checkValue("stall_pre_abort", int'(abort_o), 0);
         if (c == 8) checkValue("stall_abort", int'(abort_o), 1);
         if (c == 9) checkValue("stall_next_gnt", int'(gnt_o), 1);
      end
      checkValue("stall_abort_cycles", abort_seen, 1);
      checkValue("stall_wid", int'(word_id_o), 2);
`else
      for (int c = 0; c < 200; c++) applyStimulus(4'b1001, rnd4(), 4'b0111 & rnd4());
      checkValue("stall_hold_gnt", int'(gnt_o), 8);
      checkValue("stall_abort_cycles", abort_seen, 0);
      checkValue("stall_wid", int'(word_id_o), 2);
`endif

      // Randomized traffic against the model.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(rnd4(), rnd4(), rnd4() | rnd4());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/deser_rr_arbiter.md
DESER_RR_ARBITER -- requirements
Module: deser_rr_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 4, SHALL set the number of serial requesters (2..16).
REQ-002 Parameter DATA_W, default 16, SHALL set the word length in bits handled by the shared deserializer.
REQ-003 Parameter TIMEOUT_CYC, default 64, SHALL set the stall limit in cycles; used only when DESER_ARB_TIMEOUT_EN is defined.
REQ-004 Port list SHALL be as follows; one clock, reset asynchronous and active-high:
- clk_i  input  1  clock.
- arst_i  input  1  asynchronous active-high reset.
- req_i  input  REQ_CNT  per-requester word request.
- data_i  input  REQ_CNT  per-requester serial bit.
- data_val_i  input  REQ_CNT  per-requester bit valid.
- gnt_o  output  REQ_CNT  one-hot grant, registered.
- ser_data_o  output  1  bit to shared deserializer.
- ser_data_val_o  output  1  bit valid to shared deserializer.
- ser_srst_o  output  1  sync reset pulse to shared deserializer.
- word_id_o  output  $clog2(REQ_CNT)  index of owner of the last completed word.
- abort_o  output  1  one-cycle pulse on timeout abort.

Function
REQ-005 FSM SHALL have states IDLE and BUSY; gnt_o SHALL be all-zero in IDLE and exactly one-hot in BUSY.
REQ-006 In IDLE with any req_i bit set, the block SHALL select the first set bit scanning from (last_owner+1) mod REQ_CNT upward with wrap, register it into gnt_o and enter BUSY on the next edge.
REQ-007 In IDLE with req_i all-zero, the FSM SHALL stay in IDLE.
REQ-008 In BUSY, ser_data_o and ser_data_val_o SHALL combinationally equal data_i and data_val_i of the owner; in IDLE both SHALL be 0.
REQ-009 Non-owner data_val_i SHALL be ignored.
REQ-010 A bit counter of width $clog2(DATA_W) SHALL increment on each owner data_val_i in BUSY, starting from 0 at grant.
REQ-011 On the owner's valid bit while the counter equals DATA_W-1, the block SHALL register word_id_o with the owner index, update last_owner, clear the counter and return to IDLE on that edge.
REQ-012 Grant SHALL be held until word completion (or abort) even if the owner drops req_i.
REQ-013 Minimum gap SHALL be one IDLE cycle: last bit at cycle T, gnt_o all-zero at T+1, next grant visible at T+2.
REQ-014 word_id_o SHALL be stable from the edge after the last bit, so it is aligned with the deserializer's one-cycle-later word valid, and SHALL hold until the next completion.
REQ-015 ser_srst_o and abort_o SHALL be 0 except as stated in REQ-019.

Reset
REQ-016 When arst_i is asserted, the FSM SHALL go to IDLE immediately, independent of clk_i.
REQ-017 While arst_i is asserted: gnt_o=0, counter=0, word_id_o=0, abort_o=0, ser_srst_o=0, stall counter=0, last_owner=REQ_CNT-1 (so index 0 has first priority).
REQ-018 Reset asserted mid-word SHALL discard the partial word with no completion recorded.

Configuration
REQ-019 With macro DESER_ARB_TIMEOUT_EN defined:
- A stall counter SHALL clear on every owner valid bit and on each grant.
- It SHALL increment on each BUSY cycle without an owner valid bit.
- When it reaches TIMEOUT_CYC, the block SHALL for one cycle pulse abort_o and ser_srst_o, drop the grant, clear the bit counter, set last_owner to the aborted owner and enter IDLE.
- word_id_o SHALL remain unchanged on abort.
REQ-020 Without DESER_ARB_TIMEOUT_EN, there SHALL be no stall counter, ser_srst_o and abort_o SHALL be constant 0, and a stalled owner SHALL hold the grant indefinitely.

Verification (REQ_CNT=4, DATA_W=16)
REQ-021 req_i=4'b0101 from reset -> gnt_o=0001 for 16 valid bits, then one IDLE cycle, then gnt_o=0100; word_id_o=0 then 2.
REQ-022 req_i=4'b1111 held -> grant order 0,1,2,3,0; each 16-bit word reassembled MSB-first matches the owner's sent pattern (e.g. 0xA5C3).
REQ-023 Owner 1 drops req_i after 5 bits, with data_val_i gapped every other cycle -> gnt_o stays 0010 until bit 16; no other owner's bits reach ser_data_o.
REQ-024 arst_i pulsed after 7 bits of owner 2 -> gnt_o=0 immediately; with req_i=0100 next grant is owner 2 (last_owner reset to 3), and counter restarts at 0.
REQ-025 With DESER_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, owner 3 sends 4 bits then stalls -> abort_o and ser_srst_o high for exactly one cycle 8 cycles later; next grant goes to owner 0 if requesting; word_id_o unchanged.
REQ-026 Without the macro, same stall stimulus -> gnt_o=1000 held for 200 cycles; abort_o and ser_srst_o remain 0.
